// File: rtl/pipelined_regfile_if.sv
// Bus bundle between the decode/writeback hazard logic and the register file.
// The master drives indices, write-back data and scoreboard strobes.
// The slave returns registered read data and busy flags.
`timescale 1ns/1ps
interface pipelined_regfile_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
);
    logic [NUM_READ*ADDR_WIDTH-1:0] rdAddr;
    logic [NUM_READ*DATA_WIDTH-1:0] rdData;
    logic [NUM_READ-1:0]            rdBusy;
    logic                           wrEn;
    logic [ADDR_WIDTH-1:0]          wrAddr;
    logic [DATA_WIDTH-1:0]          wrData;
    logic                           issueEn;
    logic [ADDR_WIDTH-1:0]          issueAddr;
    logic                           flush;
    logic                           anyBusy;

    modport master (
        output rdAddr, wrEn, wrAddr, wrData, issueEn, issueAddr, flush,
        input  rdData, rdBusy, anyBusy
    );

    modport slave (
        input  rdAddr, wrEn, wrAddr, wrData, issueEn, issueAddr, flush,
        output rdData, rdBusy, anyBusy
    );
endinterface

// File: rtl/pipelined_regfile.sv
// Multi-read-port register file with write-through bypass and a per-register
// pending scoreboard. Read data, busy flags and anyBusy are registered and
// appear one cycle after the address.
`timescale 1ns/1ps
module pipelined_regfile #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int NUM_READ    = 2,
    parameter int ZERO_REG_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_regfile_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '0;

    logic [DATA_WIDTH-1:0]          r_mem [DEPTH];
    logic [DEPTH-1:0]               r_pending;
    logic [NUM_READ*DATA_WIDTH-1:0] r_rd_data;
    logic [NUM_READ-1:0]            r_rd_busy;
    logic                           r_any_busy;

    logic [DEPTH-1:0]               w_pending_nxt;
    logic [NUM_READ*DATA_WIDTH-1:0] w_rd_data_nxt;
    logic [NUM_READ-1:0]            w_rd_busy_nxt;
    logic [ADDR_WIDTH-1:0]          w_rd_addr [NUM_READ];
    logic                           w_wr_ok;
    logic                           w_issue_ok;

    // True when the index names the hard-wired zero register.
    function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] addr);
        return (ZERO_REG_EN != 0) && (addr == ZERO_ADDR);
    endfunction

    // Qualify the write and issue strobes; r0 writes/issues are dropped and flush masks issue.
    always_comb begin
        w_wr_ok    = bus.wrEn & ~is_zero_reg(bus.wrAddr);
        w_issue_ok = bus.issueEn & ~bus.flush & ~is_zero_reg(bus.issueAddr);
    end

    // Next pending vector: flush clears all, otherwise writeback clears and issue sets (issue wins).
    always_comb begin
        w_pending_nxt = r_pending;
        if (bus.flush) begin
            w_pending_nxt = '0;
        end else begin
            if (bus.wrEn) begin
                w_pending_nxt[bus.wrAddr] = 1'b0;
            end else begin
                w_pending_nxt[bus.wrAddr] = r_pending[bus.wrAddr];
            end
            if (w_issue_ok) begin
                w_pending_nxt[bus.issueAddr] = 1'b1;
            end else begin
                w_pending_nxt[bus.issueAddr] = w_pending_nxt[bus.issueAddr];
            end
        end
        if (ZERO_REG_EN != 0) begin
            w_pending_nxt[0] = 1'b0;
        end else begin
            w_pending_nxt[0] = w_pending_nxt[0];
        end
    end

    // Split the packed read-index bus into one index per port.
    always_comb begin
        for (int i = 0; i < NUM_READ; i++) begin
            w_rd_addr[i] = bus.rdAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Per-port read mux: zero register, same-edge bypass, else array; busy sees same-edge clear only.
    always_comb begin
        w_rd_data_nxt = '0;
        w_rd_busy_nxt = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            if (is_zero_reg(w_rd_addr[i])) begin
                w_rd_data_nxt[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else if (w_wr_ok && (bus.wrAddr == w_rd_addr[i])) begin
                w_rd_data_nxt[i*DATA_WIDTH +: DATA_WIDTH] = bus.wrData;
            end else begin
                w_rd_data_nxt[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[w_rd_addr[i]];
            end
            w_rd_busy_nxt[i] = r_pending[w_rd_addr[i]]
                             & ~(bus.wrEn & (bus.wrAddr == w_rd_addr[i]))
                             & ~bus.flush;
        end
    end

    // Register array storage; reset clears every word so no stale data survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[bus.wrAddr] <= bus.wrData;
        end
    end

    // Pending scoreboard and registered read-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= '0;
            r_rd_data  <= '0;
            r_rd_busy  <= '0;
            r_any_busy <= 1'b0;
        end else begin
            r_pending  <= w_pending_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_rd_busy  <= w_rd_busy_nxt;
            r_any_busy <= |w_pending_nxt;
        end
    end

    assign bus.rdData  = r_rd_data;
    assign bus.rdBusy  = r_rd_busy;
    assign bus.anyBusy = r_any_busy;

endmodule

// File: tb/tb_pipelined_regfile.sv
// Scoreboard bench for pipelined_regfile: three instances (default, r0 writable,
// and a narrow 4-port variant). The driver pushes the expected post-edge outputs
// on each drive; a monitor pops and compares just after every rising edge.
`timescale 1ns/1ps
module tb_pipelined_regfile;
    logic clk;
    logic rst_n;

    pipelined_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) if0 ();
    pipelined_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) if1 ();
    pipelined_regfile_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_READ(4)) if2 ();

    pipelined_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG_EN(1))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    pipelined_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG_EN(0))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    pipelined_regfile #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_READ(4), .ZERO_REG_EN(1))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    typedef struct {
        int               inst;
        string            nm;
        logic [3:0]       dm;
        logic [3:0][31:0] d;
        logic [3:0]       bm;
        logic [3:0]       b;
        bit               ca;
        logic             a;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within the time limit");
        $fatal(1, "timeout");
    end

    task automatic idle_all();
        if0.rdAddr = '0; if0.wrEn = 1'b0; if0.wrAddr = '0; if0.wrData = '0;
        if0.issueEn = 1'b0; if0.issueAddr = '0; if0.flush = 1'b0;
        if1.rdAddr = '0; if1.wrEn = 1'b0; if1.wrAddr = '0; if1.wrData = '0;
        if1.issueEn = 1'b0; if1.issueAddr = '0; if1.flush = 1'b0;
        if2.rdAddr = '0; if2.wrEn = 1'b0; if2.wrAddr = '0; if2.wrData = '0;
        if2.issueEn = 1'b0; if2.issueAddr = '0; if2.flush = 1'b0;
    endtask

    // Drive one cycle on instance 0 or 1 (32-bit, 5-bit index, 2 ports).
    task automatic drv32(input int inst, input logic [4:0] a0, input logic [4:0] a1,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ie, input logic [4:0] ia, input logic fl);
        @(negedge clk);
        idle_all();
        if (inst == 0) begin
            if0.rdAddr = {a1, a0}; if0.wrEn = we; if0.wrAddr = wa; if0.wrData = wd;
            if0.issueEn = ie; if0.issueAddr = ia; if0.flush = fl;
        end else begin
            if1.rdAddr = {a1, a0}; if1.wrEn = we; if1.wrAddr = wa; if1.wrData = wd;
            if1.issueEn = ie; if1.issueAddr = ia; if1.flush = fl;
        end
    endtask

    // Drive one cycle on instance 2 (16-bit, 3-bit index, 4 ports).
    task automatic drv16(input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2,
                         input logic [2:0] a3, input logic we, input logic [2:0] wa,
                         input logic [15:0] wd, input logic ie, input logic [2:0] ia,
                         input logic fl);
        @(negedge clk);
        idle_all();
        if2.rdAddr = {a3, a2, a1, a0}; if2.wrEn = we; if2.wrAddr = wa; if2.wrData = wd;
        if2.issueEn = ie; if2.issueAddr = ia; if2.flush = fl;
    endtask

    task automatic push(input int inst, input string nm, input logic [3:0] dm,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3,
                        input logic [3:0] bm, input logic [3:0] b,
                        input bit ca, input logic a);
        exp_t e;
        e.inst = inst; e.nm = nm; e.dm = dm;
        e.d[0] = d0; e.d[1] = d1; e.d[2] = d2; e.d[3] = d3;
        e.bm = bm; e.b = b; e.ca = ca; e.a = a;
        q.push_back(e);
    endtask

    // Monitor: after each rising edge, compare the outputs against the oldest expectation.
    exp_t             cur;
    logic [3:0][31:0] ad;
    logic [3:0]       ab;
    logic             aa;
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            cur = q.pop_front();
            ad = '0; ab = '0; aa = 1'b0;
            case (cur.inst)
                0: begin
                    ad[0] = if0.rdData[31:0]; ad[1] = if0.rdData[63:32];
                    ab = {2'b00, if0.rdBusy}; aa = if0.anyBusy;
                end
                1: begin
                    ad[0] = if1.rdData[31:0]; ad[1] = if1.rdData[63:32];
                    ab = {2'b00, if1.rdBusy}; aa = if1.anyBusy;
                end
                2: begin
                    ad[0] = {16'h0000, if2.rdData[15:0]};  ad[1] = {16'h0000, if2.rdData[31:16]};
                    ad[2] = {16'h0000, if2.rdData[47:32]}; ad[3] = {16'h0000, if2.rdData[63:48]};
                    ab = if2.rdBusy; aa = if2.anyBusy;
                end
                default: begin
                    ad = '0; ab = '0; aa = 1'b0;
                end
            endcase
            for (int p = 0; p < 4; p++) begin
                if (cur.dm[p]) begin
                    checks++;
                    if (ad[p] !== cur.d[p]) begin
                        errors++;
                        $display("FAIL %s dut%0d rdData%0d: got %h want %h",
                                 cur.nm, cur.inst, p, ad[p], cur.d[p]);
                    end
                end
                if (cur.bm[p]) begin
                    checks++;
                    if (ab[p] !== cur.b[p]) begin
                        errors++;
                        $display("FAIL %s dut%0d rdBusy%0d: got %b want %b",
                                 cur.nm, cur.inst, p, ab[p], cur.b[p]);
                    end
                end
            end
            if (cur.ca) begin
                checks++;
                if (aa !== cur.a) begin
                    errors++;
                    $display("FAIL %s dut%0d anyBusy: got %b want %b", cur.nm, cur.inst, aa, cur.a);
                end
            end
        end
    end

    task automatic check_zero_outputs(input string nm);
        checks++;
        if ((if0.rdData !== 64'h0) || (if0.rdBusy !== 2'b00) || (if0.anyBusy !== 1'b0) ||
            (if1.rdData !== 64'h0) || (if1.rdBusy !== 2'b00) || (if1.anyBusy !== 1'b0) ||
            (if2.rdData !== 64'h0) || (if2.rdBusy !== 4'b0000) || (if2.anyBusy !== 1'b0)) begin
            errors++;
            $display("FAIL %s: got d0=%h b0=%b a0=%b d1=%h b1=%b a1=%b d2=%h b2=%b a2=%b want all zero",
                     nm, if0.rdData, if0.rdBusy, if0.anyBusy, if1.rdData, if1.rdBusy,
                     if1.anyBusy, if2.rdData, if2.rdBusy, if2.anyBusy);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_all();
        repeat (2) @(negedge clk);
        check_zero_outputs("power_on_reset");
        rst_n = 1'b1;

        // ---- reset clears stored data and pending bits (dut0) ----
        drv32(0, 5'd5, 5'd0, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 1'b0);
        push(0, "rst_load", 4'b0011, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 4'b0011, 4'b0000, 1'b1, 1'b0);
        drv32(0, 5'd5, 5'd5, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b0);
        push(0, "rst_readback", 4'b0011, 32'h0000_1234, 32'h0000_1234, 32'h0, 32'h0, 4'b0011, 4'b0000, 1'b1, 1'b1);
        drv32(0, 5'd5, 5'd6, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        push(0, "rst_pre", 4'b0001, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 4'b0011, 4'b0010, 1'b1, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("async_reset_immediate");
        @(negedge clk);
        rst_n = 1'b1;
        drv32(0, 5'd5, 5'd6, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        push(0, "rst_after", 4'b0011, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0011, 4'b0000, 1'b1, 1'b0);

        // ---- bypass ----
        drv32(0, 5'd8, 5'd0, 1'b1, 5'd8, 32'h0000_0011, 1'b0, 5'd0, 1'b0);
        push(0, "byp_w8", 4'b0001, 32'h0000_0011, 32'h0, 32'h0, 32'h0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        drv32(0, 5'd7, 5'd8, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0);
        push(0, "byp_w7", 4'b0011, 32'hDEAD_BEEF, 32'h0000_0011, 32'h0, 32'h0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        drv32(0, 5'd7, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        push(0, "array_r7_both", 4'b0011, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 32'h0, 4'b0000, 4'b0000, 1'b0, 1'b0);

        // ---- zero register, hard-wired ----
        drv32(0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b0);
        push(0, "r0_write", 4'b0011, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0011, 4'b0000, 1'b1, 1'b0);
        drv32(0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        push(0, "r0_read", 4'b0011, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0011, 4'b0000, 1'b1, 1'b0);

        // ---- zero register, writable (dut1) ----
        drv32(1, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b0);
        push(1, "r0w_write", 4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 4'b0011, 4'b0000, 1'b1, 1'b1);
        drv32(1, 5'd0, 5'd1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        push(1, "r0w_read", 4'b0011, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 4'b0011, 4'b0001, 1'b1, 1'b1);
        drv32(1, 5'd0, 5'd0, 1'b1, 5'd0, 32'h0000_0005, 1'b0, 5'd0, 1'b0);
        push(1, "r0w_clear", 4'b0001, 32'h0000_0005, 32'h0, 32'h0, 32'h0, 4'b0011, 4'b0000, 1'b1, 1'b0);

        // ---- scoreboard issue / writeback ----
        drv32(0, 5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);
        push(0, "sb_issue3", 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0001, 4'b0000, 1'b1, 1'b1);
        drv32(0, 5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        push(0, "sb_busy3", 4'b0001, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0001, 4'b0001, 1'b1, 1'b1);
        drv32(0, 5'd3, 5'd0, 1'b1, 5'd3, 32'h0000_0009, 1'b0, 5'd0, 1'b0);
        push(0, "sb_wb3", 4'b0001, 32'h0000_0009, 32'h0, 32'h0, 32'h0, 4'b0001, 4'b0000, 1'b1, 1'b0);
        drv32(0, 5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        push(0, "sb_after3", 4'b0001, 32'h0000_0009, 32'h0, 32'h0, 32'h0, 4'b0001, 4'b0000, 1'b1, 1'b0);

        // ---- set/clear collision ----
        drv32(0, 5'd4, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0);
        push(0, "col_issue4", 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0001, 4'b0000, 1'b1, 1'b1);
        drv32(0, 5'd4, 5'd4, 1'b1, 5'd4, 32'h0000_0044, 1'b1, 5'd4, 1'b0);
        push(0, "col_both", 4'b0011, 32'h0000_0044, 32'h0000_0044, 32'h0, 32'h0, 4'b0011, 4'b0000, 1'b1, 1'b1);
        drv32(0, 5'd4, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        push(0, "col_after", 4'b0011, 32'h0000_0044, 32'h0000_0044, 32'h0, 32'h0, 4'b0011, 4'b0011, 1'b1, 1'b1);
        drv32(0, 5'd4, 5'd0, 1'b1, 5'd4, 32'h0000_0045, 1'b0, 5'd0, 1'b0);
        push(0, "col_clear", 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0001, 4'b0000, 1'b1, 1'b0);

        // ---- flush (dut0) ----
        drv32(0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0);
        push(0, "fl_i1", 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 4'b0000, 1'b1, 1'b1);
        drv32(0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0);
        push(0, "fl_i2", 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 4'b0000, 1'b1, 1'b1);
        drv32(0, 5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);
        push(0, "fl_i3", 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0011, 4'b0011, 1'b1, 1'b1);
        drv32(0, 5'd1, 5'd9, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1);
        push(0, "fl_flush", 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0011, 4'b0000, 1'b1, 1'b0);
        drv32(0, 5'd9, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        push(0, "fl_after", 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0011, 4'b0000, 1'b1, 1'b0);

        // ---- narrow 4-port variant (dut2) ----
        drv16(3'd7, 3'd0, 3'd1, 3'd2, 1'b1, 3'd7, 16'hBEEF, 1'b1, 3'd1, 1'b0);
        push(2, "n_w7", 4'b1111, 32'h0000_BEEF, 32'h0, 32'h0, 32'h0, 4'b1111, 4'b0000, 1'b1, 1'b1);
        drv16(3'd1, 3'd7, 3'd7, 3'd2, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 1'b0);
        push(2, "n_i2", 4'b0110, 32'h0, 32'h0000_BEEF, 32'h0000_BEEF, 32'h0, 4'b1111, 4'b0001, 1'b1, 1'b1);
        drv16(3'd1, 3'd2, 3'd3, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 1'b0);
        push(2, "n_i3", 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 4'b1111, 4'b0011, 1'b1, 1'b1);
        drv16(3'd1, 3'd2, 3'd3, 3'd5, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 1'b1);
        push(2, "n_flush", 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 4'b1111, 4'b0000, 1'b1, 1'b0);
        drv16(3'd1, 3'd2, 3'd3, 3'd5, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0);
        push(2, "n_after", 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 4'b1111, 4'b0000, 1'b1, 1'b0);
        drv16(3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 1'b0);
        push(2, "n_r0", 4'b1111, 32'h0, 32'h0, 32'h0, 32'h0, 4'b1111, 4'b0000, 1'b1, 1'b0);

        @(negedge clk);
        idle_all();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
